// File: rtl/pixpack_pkg.sv
// Shared types and constants for the pixel write packer.
package pixpack_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  // Widest supported byte address; narrower ADDR_W values zero-extend into word_t.addr.
  localparam int unsigned PIX_ADDR_W     = 32;
  localparam int unsigned WORD_ADDR_W    = PIX_ADDR_W - 2;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StFlush,
    StDrain,
    StDone
  } pack_state_e;

  typedef struct packed {
    logic [WORD_ADDR_W-1:0]      addr;
    logic [8*BYTES_PER_WORD-1:0] data;
    logic [BYTES_PER_WORD-1:0]   be;
  } word_t;

  // One-hot byte-enable bit for a byte lane.
  function automatic logic [BYTES_PER_WORD-1:0] lane_onehot(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/pixpack_fifo.sv
// First-word-fall-through FIFO of packed words. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; otherwise it is dropped and flagged on drop_o.
module pixpack_fifo
  import pixpack_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_i,
  input  word_t push_word_i,
  input  logic  pop_i,
  output word_t head_o,
  output logic  empty_o,
  output logic  full_o,
  output logic  drop_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = 1;

  word_t           mem_q [Depth];
  logic [PtrW:0]   wptr_q, wptr_d;
  logic [PtrW:0]   rptr_q, rptr_d;
  logic            push_ok;
  logic            pop_ok;

  // Status flags, accept decisions and next pointers.
  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
              (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    pop_ok  = pop_i && !empty_o;
    push_ok = push_i && (!full_o || pop_ok);
    drop_o  = push_i && !push_ok;
    wptr_d  = push_ok ? wptr_q + PtrOne : wptr_q;
    rptr_d  = pop_ok ? rptr_q + PtrOne : rptr_q;
    head_o  = mem_q[rptr_q[PtrW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage; contents are don't-care until pointed at by a valid entry.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q[PtrW-1:0]] <= push_word_i;
    end
  end

endmodule

// File: rtl/pixel_write_packer.sv
// Packs the bilinear core's byte writes into 32-bit little-endian words with byte
// enables, buffers them and drains them to a word-wide memory port.
// Optional macro PACK_STATS_EN adds stat_words_o / stat_stall_o counters.
module pixel_write_packer
  import pixpack_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [31:0]       total_pix_i,
  input  logic              wr_valid_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [7:0]        wr_data_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic [3:0]        mem_be_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_err_o,
  output logic              order_err_o
`ifdef PACK_STATS_EN
  ,
  output logic [31:0]       stat_words_o,
  output logic [31:0]       stat_stall_o
`endif
);

  pack_state_e       state_q, state_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       total_q, total_d;
  logic [31:0]       acc_data_q, acc_data_d;
  logic [3:0]        acc_be_q, acc_be_d;
  logic [ADDR_W-3:0] acc_idx_q, acc_idx_d;
  logic              overflow_q, overflow_d;
  logic              order_q, order_d;

  logic              push;
  word_t             push_word;
  word_t             head;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_drop;
  logic              pop;

  logic [ADDR_W-3:0] wr_idx;
  logic [1:0]        wr_lane;
  logic [3:0]        lane_mask;
  logic [31:0]       merged_data;
  logic [31:0]       fresh_data;

  function automatic word_t mk_word(input logic [ADDR_W-3:0] idx, input logic [31:0] data,
                                    input logic [3:0] be);
    word_t w;
    w = '0;
    w.addr[ADDR_W-3:0] = idx;
    w.data = data;
    w.be   = be;
    return w;
  endfunction

  // Incoming byte placed into the open word, and into an otherwise empty word.
  always_comb begin
    wr_idx    = wr_addr_i[ADDR_W-1:2];
    wr_lane   = wr_addr_i[1:0];
    lane_mask = lane_onehot(wr_lane);
    for (int k = 0; k < 4; k++) begin
      merged_data[8*k +: 8] = (wr_lane == 2'(k)) ? wr_data_i : acc_data_q[8*k +: 8];
      fresh_data[8*k +: 8]  = (wr_lane == 2'(k)) ? wr_data_i : 8'h00;
    end
  end

  // Frame FSM, accumulator and push generation.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    total_d    = total_q;
    acc_data_d = acc_data_q;
    acc_be_d   = acc_be_q;
    acc_idx_d  = acc_idx_q;
    overflow_d = overflow_q;
    order_d    = order_q;
    push       = 1'b0;
    push_word  = '0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          total_d    = total_pix_i;
          count_d    = '0;
          overflow_d = 1'b0;
          order_d    = 1'b0;
          state_d    = (total_pix_i == '0) ? StDone : StCollect;
        end
      end
      StCollect: begin
        if (wr_valid_i) begin
          count_d = count_q + 32'd1;
          if ((acc_be_q == 4'b0000) || (wr_idx == acc_idx_q)) begin
            if ((acc_be_q & lane_mask) != 4'b0000) begin
              order_d = 1'b1;
            end
            if (wr_lane == 2'd3) begin
              // Lane 3 completes the word: push it including this byte.
              push       = 1'b1;
              push_word  = mk_word(wr_idx, merged_data, acc_be_q | lane_mask);
              acc_data_d = '0;
              acc_be_d   = '0;
            end else begin
              acc_data_d = merged_data;
              acc_be_d   = acc_be_q | lane_mask;
            end
            acc_idx_d = wr_idx;
          end else begin
            // New word index: retire the open word; the new byte stays open even on
            // lane 3 because only one push fits per cycle.
            push       = 1'b1;
            push_word  = mk_word(acc_idx_q, acc_data_q, acc_be_q);
            acc_data_d = fresh_data;
            acc_be_d   = lane_mask;
            acc_idx_d  = wr_idx;
          end
          if (count_d == total_q) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (acc_be_q != 4'b0000) begin
          push      = 1'b1;
          push_word = mk_word(acc_idx_q, acc_data_q, acc_be_q);
        end
        acc_data_d = '0;
        acc_be_d   = '0;
        state_d    = StDrain;
      end
      StDrain: begin
        if (fifo_empty) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (fifo_drop) begin
      overflow_d = 1'b1;
    end
  end

  // Frame state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      total_q    <= '0;
      acc_data_q <= '0;
      acc_be_q   <= '0;
      acc_idx_q  <= '0;
      overflow_q <= 1'b0;
      order_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      total_q    <= total_d;
      acc_data_q <= acc_data_d;
      acc_be_q   <= acc_be_d;
      acc_idx_q  <= acc_idx_d;
      overflow_q <= overflow_d;
      order_q    <= order_d;
    end
  end

  pixpack_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_word_i (push_word),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .drop_o      (fifo_drop)
  );

  // Memory port and status outputs; word fields are zeroed while no word is valid.
  always_comb begin
    mem_valid_o    = !fifo_empty;
    pop            = mem_valid_o && mem_ready_i;
    mem_addr_o     = mem_valid_o ? head.addr[ADDR_W-3:0] : '0;
    mem_data_o     = mem_valid_o ? head.data : '0;
    mem_be_o       = mem_valid_o ? head.be : '0;
    busy_o         = (state_q != StIdle);
    done_o         = (state_q == StDone);
    overflow_err_o = overflow_q;
    order_err_o    = order_q;
  end

`ifdef PACK_STATS_EN
  logic [31:0] stat_words_q, stat_stall_q;

  // Word/stall counters; cleared on an accepted start, frozen once back in idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words_q <= '0;
      stat_stall_q <= '0;
    end else if (state_q == StIdle) begin
      if (start_i) begin
        stat_words_q <= '0;
        stat_stall_q <= '0;
      end
    end else begin
      if (pop) begin
        stat_words_q <= stat_words_q + 32'd1;
      end
      if (mem_valid_o && !mem_ready_i) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
    end
  end

  assign stat_words_o = stat_words_q;
  assign stat_stall_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_pixel_write_packer.sv
// Directed scoreboard bench for pixel_write_packer.
module tb_pixel_write_packer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] total_pix;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [29:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic        busy;
  logic        done;
  logic        overflow_err;
  logic        order_err;
`ifdef PACK_STATS_EN
  logic [31:0] stat_words;
  logic [31:0] stat_stall;
`endif

  pixel_write_packer #(
    .ADDR_W     (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start),
    .total_pix_i    (total_pix),
    .wr_valid_i     (wr_valid),
    .wr_addr_i      (wr_addr),
    .wr_data_i      (wr_data),
    .mem_valid_o    (mem_valid),
    .mem_ready_i    (mem_ready),
    .mem_addr_o     (mem_addr),
    .mem_data_o     (mem_data),
    .mem_be_o       (mem_be),
    .busy_o         (busy),
    .done_o         (done),
    .overflow_err_o (overflow_err),
    .order_err_o    (order_err)
`ifdef PACK_STATS_EN
    ,
    .stat_words_o   (stat_words),
    .stat_stall_o   (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [65:0] sb_q[$];
  int          cycle = 0;
  int          done_cnt = 0;
  int          done_cycle = 0;
  int          last_pop_cycle = 0;
  logic [7:0]  img [256];

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [65:0] w(input logic [29:0] a, input logic [31:0] d,
                                    input logic [3:0] b);
    return {a, d, b};
  endfunction

  // Output monitor: every accepted word is compared with the scoreboard head.
  always @(negedge clk) begin
    cycle++;
    if (done) begin
      done_cnt++;
      done_cycle = cycle;
    end
    if (rst_n && mem_valid && mem_ready) begin
      last_pop_cycle = cycle;
      if (sb_q.size() == 0) begin
        check("unexpected_word", {mem_addr, mem_data, mem_be}, 96'd0);
      end else begin
        check("mem_word", {mem_addr, mem_data, mem_be}, sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] n);
    start     = 1'b1;
    total_pix = n;
    tick();
    start     = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done_cnt > d0) break;
    end
    @(negedge clk);
    check(tag, 96'(done_cnt > d0), 96'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, {mem_valid, busy, done, overflow_err, order_err}, 96'd0);
  endtask

  initial begin
    int d0;
    rst_n     = 1'b0;
    start     = 1'b0;
    total_pix = '0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    mem_ready = 1'b1;
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);

    // Reset state.
    tick();
    tick();
    check_idle_outputs("reset_outputs");
    check("reset_word", {mem_addr, mem_data, mem_be}, 96'd0);
    rst_n = 1'b1;
    tick();

    // 1: 256 sequential bytes, ready always high.
    for (int i = 0; i < 64; i++) begin
      sb_q.push_back(w(30'(i), {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]}, 4'hF));
    end
    d0 = done_cnt;
    do_start(32'd256);
    check("t1_busy", busy, 1'b1);
    for (int i = 0; i < 256; i++) wr(32'(i), img[i]);
    wait_done("t1_done", 50);
    repeat (3) @(negedge clk);
    check("t1_done_once", 96'(done_cnt - d0), 96'd1);
    check("t1_done_delay", 96'(done_cycle - last_pop_cycle), 96'd2);
    check("t1_sb_empty", 96'(sb_q.size()), 96'd0);
    check_idle_outputs("t1_idle");

    // 2: six bytes, trailing partial word pushed by flush.
    sb_q.push_back(w(30'd0, {img[3], img[2], img[1], img[0]}, 4'hF));
    sb_q.push_back(w(30'd1, {16'h0000, img[5], img[4]}, 4'b0011));
    do_start(32'd6);
    for (int i = 0; i < 6; i++) wr(32'(i), img[i]);
    wait_done("t2_done", 50);
    check("t2_sb_empty", 96'(sb_q.size()), 96'd0);
    check("t2_flags", {overflow_err, order_err}, 96'd0);

    // 3: word index change pushes the open partial word.
    sb_q.push_back(w(30'd0, {16'h0000, img[11], img[10]}, 4'b0011));
    sb_q.push_back(w(30'd2, {24'h000000, img[12]}, 4'b0001));
    do_start(32'd3);
    wr(32'd0, img[10]);
    wr(32'd1, img[11]);
    wr(32'd8, img[12]);
    wait_done("t3_done", 50);
    check("t3_sb_empty", 96'(sb_q.size()), 96'd0);
    check("t3_order", order_err, 1'b0);

    // 4: ready held low, 24 bytes: four words held, two dropped.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(w(30'(i), {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]}, 4'hF));
    end
    d0 = done_cnt;
    do_start(32'd24);
    for (int i = 0; i < 24; i++) wr(32'(i), img[i]);
    repeat (4) @(negedge clk);
    check("t4_held_valid", mem_valid, 1'b1);
    check("t4_overflow", overflow_err, 1'b1);
    check("t4_busy", busy, 1'b1);
    check("t4_no_done", 96'(done_cnt - d0), 96'd0);
    check("t4_head_stable", {mem_addr, mem_be}, {30'd0, 4'hF});
    tick();
    mem_ready = 1'b1;
    wait_done("t4_done", 50);
    check("t4_sb_empty", 96'(sb_q.size()), 96'd0);

    // 5: lane rewritten inside the open word.
    sb_q.push_back(w(30'd1, {8'h00, 8'h5A, 8'h22, 8'hA5}, 4'b0111));
    do_start(32'd4);
    wr(32'd4, 8'hA5);
    wr(32'd5, 8'h11);
    wr(32'd5, 8'h22);
    wr(32'd6, 8'h5A);
    wait_done("t5_done", 50);
    check("t5_order", order_err, 1'b1);
    check("t5_sb_empty", 96'(sb_q.size()), 96'd0);

    // 6: reset mid-frame discards everything; next frame is clean.
    mem_ready = 1'b0;
    do_start(32'd20);
    check("t6_flags_cleared", order_err, 1'b0);
    wr(32'd0, 8'h01);
    wr(32'd0, 8'h02);
    for (int i = 1; i < 9; i++) wr(32'(i), 8'(i));
    check("t6_pre_order", order_err, 1'b1);
    check("t6_pre_valid", mem_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t6_async_reset");
    tick();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (3) tick();
    check("t6_no_partial", mem_valid, 1'b0);
    sb_q.push_back(w(30'd0, {8'h44, 8'h33, 8'h22, 8'h11}, 4'hF));
    do_start(32'd4);
    wr(32'd0, 8'h11);
    wr(32'd1, 8'h22);
    wr(32'd2, 8'h33);
    wr(32'd3, 8'h44);
    wait_done("t6_done", 50);
    check("t6_sb_empty", 96'(sb_q.size()), 96'd0);
    check_idle_outputs("t6_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pixel_write_packer.md
Name: pixel_write_packer

Overview:
Receiving end of the bilinear core's pixel write interface (wr_valid/wr_addr/wr_data).
- Gathers byte writes into 32-bit little-endian words with byte enables.
- Buffers packed words in a small FIFO and presents them to a word-wide memory port with a valid/ready handshake.
- Signals completion once the programmed number of pixels has been received and fully drained.
- Sits between bilinear_core_scalar and the output frame buffer/DMA.

Parameters:
- ADDR_W, 32, width of byte address from core.
- FIFO_DEPTH, 4, packed-word FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; captures total_pix, clears sticky flags, enters COLLECT
- total_pix  in  32  pixels expected in this frame (out_w*out_h)
- wr_valid  in  1  core byte write strobe (no backpressure exists)
- wr_addr  in  ADDR_W  core byte address
- wr_data  in  8  core pixel byte
- mem_valid  out  1  word available at FIFO head
- mem_ready  in  1  memory accepts word
- mem_addr  out  ADDR_W-2  word address (= byte address >> 2)
- mem_data  out  32  packed word; lane k = byte address 4n+k
- mem_be  out  4  byte enables of packed word
- busy  out  1  high from start until done
- done  out  1  one-cycle completion pulse
- overflow_err  out  1  sticky: a word was dropped on a full FIFO
- order_err  out  1  sticky: a lane was rewritten within the open word

Behaviour:
- Reset: all outputs 0, FIFO empty, accumulator empty, pixel counter 0, FSM IDLE.
- FSM states: IDLE, COLLECT, FLUSH, DRAIN, DONE.
- IDLE:
  - start → COLLECT, with count=0 and flags cleared.
  - start with total_pix=0 → DONE.
  - wr_valid is ignored.
- COLLECT: on wr_valid, count increments and the byte is accumulated.
  - If the accumulator is empty or wr_addr[ADDR_W-1:2] equals the open word index, write lane wr_addr[1:0] and set its be bit.
  - If that be bit was already set, overwrite the lane and set order_err.
  - If the word index differs, push the open word, then open a new word holding only this byte.
  - If lane 3 is written, push the word (including the new byte) in the same cycle and leave the accumulator empty.
  - At most one push per cycle.
  - When count reaches total_pix → FLUSH. A wr_valid in the same cycle is counted first.
- FLUSH:
  - Push the open word if non-empty.
  - Always → DRAIN after one cycle.
- DRAIN: when the FIFO is empty and no handshake is pending → DONE.
- DONE: done=1 for one cycle → IDLE. busy is high in COLLECT, FLUSH, DRAIN and DONE.
- wr_valid outside COLLECT is ignored and not counted.
- Push into a full FIFO:
  - The word is dropped and overflow_err is set.
  - Pixel counting continues.
  - A simultaneous pop in the same cycle frees space, so the push succeeds.
- FIFO is first-word-fall-through. mem_valid asserts the cycle after the pushing edge. mem_addr/mem_data/mem_be are stable while mem_valid && !mem_ready. Pop occurs on mem_valid && mem_ready.
- start while busy is ignored.
- Reset mid-frame discards the FIFO and accumulator immediately; no partial word is emitted.

Optional Feature:
PACK_STATS_EN
- Defined: adds outputs stat_words (32) and stat_stall (32).
  - Both clear on start.
  - stat_words counts words accepted (pop).
  - stat_stall counts cycles with mem_valid && !mem_ready.
  - Both freeze after done.
- Undefined: the ports and counters do not exist.

Decomposition:
- Shared package pixpack_pkg holds:
  - state enum (IDLE, COLLECT, FLUSH, DRAIN, DONE);
  - BYTES_PER_WORD=4;
  - word struct {addr, data, be}.
- One natural sub-module, pixpack_fifo: parameterised FWFT FIFO of the word struct, with full/empty and simultaneous push/pop support.

Test Plan:
1. total_pix=256, addresses 0..255 sequential, mem_ready=1 → 64 words, mem_addr 0..63, mem_be=4'hF, word 0 = {img[3],img[2],img[1],img[0]}; done pulses once, exactly 1 cycle after DRAIN sees empty.
2. total_pix=6, addresses 0..5 → word0 be=4'hF; word1 addr=1, be=4'b0011, upper lanes 0, pushed by FLUSH.
3. total_pix=3, addresses 0,1,8 → word0 be=4'b0011; word2 be=4'b0001; no order_err.
4. mem_ready=0, continuous 24-byte stream, FIFO_DEPTH=4 → 4 words held; 5th and 6th dropped; overflow_err=1. Raise mem_ready → exactly 4 words emitted, then done.
5. Address 5 written twice with 0x11 then 0x22 → lane1 of word1 = 0x22, order_err=1.
6. rst_n low after 10 pixels → mem_valid, busy, done, flags all 0 asynchronously; after release, a new start with total_pix=4 at addresses 0..3 → one clean word.
